sl_ahb_rom_ctrl: RTL



---
 rtl/sl_ahb_rom_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/sl_ahb_rom_ctrl.sv
// ---------------------------------------------------------------------------
// sl_ahb_rom_ctrl
//
// AHB-Lite read-only slave in front of a synchronous ROM macro. A single-line
// read buffer holds the last ROM word fetched. Reads that hit the line finish
// with zero wait states. Reads that miss fetch the word over the ROM port,
// which has a configurable latency. Writes and transfers wider than 32 bits
// get a two-cycle ERROR response. Two saturating counters record read hits
// and read misses.
//
// Ports
//   HCLK, HRESET     clock, asynchronous active-high reset
//   HSEL, HREADY,    AHB-Lite address-phase inputs
//   HTRANS, HSIZE,
//   HWRITE, HADDR
//   HWDATA           write data, not used (the ROM cannot be written)
//   HREADYOUT, HRESP AHB-Lite data-phase response, registered
//   HRDATA           read data, registered; holds until the next read completes
//   ROM_CS           one-cycle read strobe to the ROM
//   ROM_ADDR         ROM word address, held after each strobe
//   ROM_RDATA        ROM word, valid RD_LAT cycles after ROM_CS
//   INVALIDATE       pulse that clears the line buffer on the next edge
//   HIT_CNT          saturating read-hit counter
//   MISS_CNT         saturating read-miss counter
// ---------------------------------------------------------------------------
module sl_ahb_rom_ctrl #(
  parameter int ADDR_W     = 14,
  parameter int SYS_DATA_W = 32,
  parameter int ROM_DATA_W = 64,
  parameter int RD_LAT     = 1,
  parameter int CNT_W      = 16
) (
  input  logic                                     HCLK,
  input  logic                                     HRESET,
  input  logic                                     HSEL,
  input  logic                                     HREADY,
  input  logic [1:0]                               HTRANS,
  input  logic [2:0]                               HSIZE,
  input  logic                                     HWRITE,
  input  logic [ADDR_W-1:0]                        HADDR,
  input  logic [SYS_DATA_W-1:0]                    HWDATA,
  output logic                                     HREADYOUT,
  output logic                                     HRESP,
  output logic [SYS_DATA_W-1:0]                    HRDATA,
  output logic                                     ROM_CS,
  output logic [ADDR_W-$clog2(ROM_DATA_W/8)-1:0]   ROM_ADDR,
  input  logic [ROM_DATA_W-1:0]                    ROM_RDATA,
  input  logic                                     INVALIDATE,
  output logic [CNT_W-1:0]                         HIT_CNT,
  output logic [CNT_W-1:0]                         MISS_CNT
);

  // Byte-offset bits that select a byte inside one ROM word.
  localparam int BYTE_BITS = $clog2(ROM_DATA_W / 8);
  // Width of a ROM word address.
  localparam int WORD_AW   = ADDR_W - BYTE_BITS;
  // Number of bus-width lanes in one ROM word.
  localparam int NLANES    = ROM_DATA_W / SYS_DATA_W;
  localparam int LANE_W    = (NLANES > 1) ? $clog2(NLANES) : 1;
  // The wait counter counts down from RD_LAT-1 to 0.
  localparam int WAIT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    FILL,
    ERR1,
    ERR2
  } state_t;

  state_t                  state;
  logic [WAIT_W-1:0]       wait_cnt;
  logic [LANE_W-1:0]       lane_reg;
  logic [ROM_DATA_W-1:0]   line_buf;
  logic [WORD_AW-1:0]      line_tag;
  logic                    line_valid;

  logic                    accept;
  logic                    req_err;
  logic                    req_hit;
  logic [WORD_AW-1:0]      addr_word;
  logic [LANE_W-1:0]       addr_lane;

  // HWDATA is meaningless for a ROM. The byte offset inside a 32-bit lane is
  // not needed because narrow reads return the whole lane. HTRANS[0] only
  // separates SEQ from NONSEQ, and both are handled the same way.
  logic unused_ok;
  assign unused_ok = ^{HWDATA, HADDR[1:0], HTRANS[0]};

  assign addr_word = HADDR[ADDR_W-1:BYTE_BITS];

  // The lane index exists only when a ROM word is wider than the bus.
  generate
    if (NLANES > 1) begin : g_lane
      assign addr_lane = HADDR[BYTE_BITS-1:2];
    end else begin : g_nolane
      assign addr_lane = '0;
    end
  endgenerate

  // Address-phase decode. This is a valid NONSEQ/SEQ transfer addressed to us.
  // It is acted on only in states where HREADYOUT is already 1.
  assign accept  = HSEL & HREADY & HTRANS[1];
  assign req_err = HWRITE | (HSIZE > 3'd2);
  assign req_hit = line_valid & (line_tag == addr_word);

  function automatic logic [SYS_DATA_W-1:0] pick_lane(
    input logic [ROM_DATA_W-1:0] word,
    input logic [LANE_W-1:0]     lane
  );
    return word[int'(lane) * SYS_DATA_W +: SYS_DATA_W];
  endfunction

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state      <= IDLE;
      wait_cnt   <= '0;
      lane_reg   <= '0;
      line_buf   <= '0;
      line_tag   <= '0;
      line_valid <= 1'b0;
      HREADYOUT  <= 1'b1;
      HRESP      <= 1'b0;
      HRDATA     <= '0;
      ROM_CS     <= 1'b0;
      ROM_ADDR   <= '0;
      HIT_CNT    <= '0;
      MISS_CNT   <= '0;
    end else begin
      // The strobe lasts one cycle. It is raised only on entry to FETCH.
      ROM_CS <= 1'b0;

      case (state)
        // These states drive HREADYOUT=1, so a new address phase can be
        // accepted here.
        IDLE, FILL, ERR2: begin
          if (accept) begin
            if (req_err) begin
              state     <= ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else if (req_hit) begin
              // Zero-wait hit. The data phase is the next cycle.
              state     <= IDLE;
              HREADYOUT <= 1'b1;
              HRESP     <= 1'b0;
              HRDATA    <= pick_lane(line_buf, addr_lane);
              if (!(&HIT_CNT)) begin
                HIT_CNT <= HIT_CNT + 1'b1;
              end
            end else begin
              state     <= FETCH;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b0;
              ROM_CS    <= 1'b1;
              ROM_ADDR  <= addr_word;
              lane_reg  <= addr_lane;
              if (!(&MISS_CNT)) begin
                MISS_CNT <= MISS_CNT + 1'b1;
              end
            end
          end else begin
            state     <= IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
          end
        end

        // The strobe is on the ROM port during this cycle.
        FETCH: begin
          state    <= WAIT;
          wait_cnt <= WAIT_W'(RD_LAT - 1);
        end

        // ROM_RDATA is valid in the last WAIT cycle, RD_LAT cycles after the
        // strobe. The buffer and the bus data are both loaded on that edge.
        WAIT: begin
          if (wait_cnt == '0) begin
            state      <= FILL;
            line_buf   <= ROM_RDATA;
            line_tag   <= ROM_ADDR;
            line_valid <= 1'b1;
            HRDATA     <= pick_lane(ROM_RDATA, lane_reg);
            HREADYOUT  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end

        ERR1: begin
          state     <= ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end

        default: begin
          state     <= IDLE;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
        end
      endcase

      // Invalidation has priority over a fill on the same edge. The captured
      // word is still returned to the bus, but it does not stay cached. A hit
      // accepted on the same edge has already loaded HRDATA from the buffer.
      if (INVALIDATE) begin
        line_valid <= 1'b0;
      end
    end
  end

endmodule
